// File: rtl/cla_bist_pkg.sv
// Shared types and constants for the 4-bit carry-lookahead adder self-test.
package cla_bist_pkg;

   // Sweep controller states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Vector index: A = vec[8:5], B = vec[4:1], c_in = vec[0].
   localparam int VEC_W = 9;
   localparam logic [VEC_W-1:0] LAST_VEC = 9'd511;

   // Error counter must hold 0..512 without saturating.
   localparam int ERR_W = 10;

   // Settle counter width; covers the legal settle range 1..15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/cla_golden_ref.sv
// Combinational behavioural reference: 5-bit result of A + B + c_in.
module cla_golden_ref (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [4:0] o_sum
);

   // Plain arithmetic sum; bit 4 is the expected carry-out.
   always_comb begin
      o_sum = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
   end

endmodule

// File: rtl/cla_bist_4bit.sv
// Self-test driver/checker for the 4-bit carry-lookahead adder.
// Sweeps all 512 operand combinations, holds each for SETTLE_CYCLES
// cycles, then compares the adder result with a golden sum.
//
// start protocol: start is a level, sampled on every rising edge while
// the block is not busy (IDLE or DONE). A high sample launches a sweep on
// that edge. While busy, start is ignored. done is held until the next
// accepted start or rst, so a start still high at the end of a sweep
// launches the next sweep one edge after done rises.
module cla_bist_4bit
   import cla_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [3:0]       dut_a,
   output logic [3:0]       dut_b,
   output logic             dut_cin,
   input  logic [3:0]       dut_sum,
   input  logic             dut_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] fail_vec,
   output state_t           o_dbg_state
);

   // Last settle count value before moving to CHECK.
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [VEC_W-1:0]   r_vec;
   logic [VEC_W-1:0]   w_vec_nxt;
   logic [CNT_W-1:0]   r_settle;
   logic [CNT_W-1:0]   w_settle_nxt;
   logic [ERR_W-1:0]   r_err;
   logic [ERR_W-1:0]   w_err_nxt;
   logic [VEC_W-1:0]   r_fail;
   logic [VEC_W-1:0]   w_fail_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               r_done;
   logic               w_done_nxt;

   logic [4:0]         w_gold;
   logic               w_mismatch;

   // Golden result for the operands currently driven to the adder.
   cla_golden_ref u_golden (
      .i_a   (r_vec[8:5]),
      .i_b   (r_vec[4:1]),
      .i_cin (r_vec[0]),
      .o_sum (w_gold)
   );

   // Any difference in sum or carry-out counts as a failing vector.
   always_comb begin
      w_mismatch = ({dut_cout, dut_sum} != w_gold);
   end

   // Next-state and next-value logic for the sweep controller.
   always_comb begin
      w_state_nxt  = r_state;
      w_vec_nxt    = r_vec;
      w_settle_nxt = r_settle;
      w_err_nxt    = r_err;
      w_fail_nxt   = r_fail;
      w_busy_nxt   = r_busy;
      w_done_nxt   = r_done;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt  = ST_SETTLE;
               w_vec_nxt    = '0;
               w_settle_nxt = '0;
               w_err_nxt    = '0;
               w_fail_nxt   = '0;
               w_busy_nxt   = 1'b1;
               w_done_nxt   = 1'b0;
            end
         end

         ST_SETTLE: begin
            // Counter starts at 0 on entry, so SETTLE lasts SETTLE_CYCLES edges.
            if (r_settle == SETTLE_LAST) begin
               w_state_nxt  = ST_CHECK;
               w_settle_nxt = '0;
            end else begin
               w_settle_nxt = r_settle + 1'b1;
            end
         end

         ST_CHECK: begin
            if (w_mismatch) begin
               w_err_nxt = r_err + 1'b1;
               // Only the first failing index is recorded.
               if (r_err == '0) begin
                  w_fail_nxt = r_vec;
               end
            end
            if (r_vec == LAST_VEC) begin
               w_state_nxt = ST_DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt  = ST_SETTLE;
               w_vec_nxt    = r_vec + 1'b1;
               w_settle_nxt = '0;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; rst wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_vec    <= '0;
         r_settle <= '0;
         r_err    <= '0;
         r_fail   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_vec    <= w_vec_nxt;
         r_settle <= w_settle_nxt;
         r_err    <= w_err_nxt;
         r_fail   <= w_fail_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Operands come straight from the vector register.
   always_comb begin
      dut_a       = r_vec[8:5];
      dut_b       = r_vec[4:1];
      dut_cin     = r_vec[0];
      busy        = r_busy;
      done        = r_done;
      pass        = r_done & (r_err == '0);
      err_count   = r_err;
      fail_vec    = r_fail;
      o_dbg_state = r_state;
   end

endmodule

// File: tb/tb_cla_bist_4bit.sv
// Testbench for cla_bist_4bit: two instances (settle 1 and settle 3)
// driven by a behavioural adder stand-in with selectable faults.
module tb_cla_bist_4bit;
   import cla_bist_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start;

   // ---------------- instance with settle = 1 ----------------
   logic [3:0] a1, b1, sum1;
   logic       c1, cout1, busy1, done1, pass1;
   logic [9:0] err1;
   logic [8:0] fail1;
   state_t     st1;
   logic [4:0] res1;

   // ---------------- instance with settle = 3 ----------------
   logic [3:0] a3, b3, sum3;
   logic       c3, cout3, busy3, done3, pass3;
   logic [9:0] err3;
   logic [8:0] fail3;
   state_t     st3;
   logic [4:0] res3;

   // ---------------- fault control ----------------
   int         fault_mode;       // 0 good, 1 sum[0] stuck 0, 2 cout stuck 0, 3 random map
   logic       fault_map [0:511];
   logic [4:0] fault_mask;

   int total;
   int bad;

   cla_bist_4bit #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start),
      .dut_a(a1), .dut_b(b1), .dut_cin(c1),
      .dut_sum(sum1), .dut_cout(cout1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fail1), .o_dbg_state(st1)
   );

   cla_bist_4bit #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start),
      .dut_a(a3), .dut_b(b3), .dut_cin(c3),
      .dut_sum(sum3), .dut_cout(cout3),
      .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_vec(fail3), .o_dbg_state(st3)
   );

   // ---------------- reference model ----------------
   // True A + B + c_in for a vector index, from plain integer arithmetic.
   function automatic int true_result(input int idx);
      return (idx >> 5) + ((idx >> 1) & 15) + (idx & 1);
   endfunction

   // Adder stand-in: true result with the selected fault applied.
   function automatic logic [4:0] adder_out(input int idx, input int mode,
                                            input logic fbit, input logic [4:0] mask);
      int t;
      t = true_result(idx);
      case (mode)
         1: t = t & 30;
         2: t = t & 15;
         3: if (fbit) t = t ^ int'(mask);
         default: ;
      endcase
      return 5'(t);
   endfunction

   always_comb begin
      res1  = adder_out(int'({a1, b1, c1}), fault_mode, fault_map[{a1, b1, c1}], fault_mask);
      sum1  = res1[3:0];
      cout1 = res1[4];
   end

   always_comb begin
      res3  = adder_out(int'({a3, b3, c3}), fault_mode, fault_map[{a3, b3, c3}], fault_mask);
      sum3  = res3[3:0];
      cout3 = res3[4];
   end

   // Scoreboard: queue of indices the adder stand-in will get wrong.
   logic [8:0] exp_q [$];

   task automatic build_expected();
      exp_q.delete();
      for (int idx = 0; idx < 512; idx++) begin
         if (adder_out(idx, fault_mode, fault_map[idx], fault_mask) != 5'(true_result(idx)))
            exp_q.push_back(9'(idx));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_faults();
      fault_mode = 0;
      fault_mask = 5'd1;
      for (int i = 0; i < 512; i++) fault_map[i] = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Raise start before an edge; returns #1 after the accepting edge.
   task automatic start_sweep(input int keep);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (keep == 0) start = 1'b0;
   endtask

   // Counts edges until done of the chosen instance; -1 if budget expires.
   task automatic wait_done(input int which, input int budget,
                            output int edges, output int busy_cnt);
      edges    = -1;
      busy_cnt = 0;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk);
         #1;
         if ((which == 1) ? done1 : done3) begin
            edges = n;
            break;
         end
         if ((which == 1) ? busy1 : busy3) busy_cnt++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({a1, b1, c1, busy1, done1, pass1, err1, fail1} !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs_s1: got %h want 0", {a1, b1, c1, busy1, done1, pass1, err1, fail1});
      end
      total++;
      if ({a3, b3, c3, busy3, done3, pass3, err3, fail3} !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs_s3: got %h want 0", {a3, b3, c3, busy3, done3, pass3, err3, fail3});
      end
      total++;
      if (st1 !== ST_IDLE || st3 !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_state: got %0d/%0d want %0d", st1, st3, ST_IDLE);
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_clean_sweep();
      int edges, bcnt, bacc;
      apply_reset();
      clear_faults();
      start_sweep(0);
      bacc = busy1 ? 1 : 0;
      total++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         bad++;
         $display("FAIL clean_accept: got busy=%b done=%b want busy=1 done=0", busy1, done1);
      end
      wait_done(1, 1100, edges, bcnt);
      total++;
      if (edges != 1024) begin
         bad++;
         $display("FAIL clean_latency: got %0d want 1024", edges);
      end
      total++;
      if (bcnt + bacc != 1024) begin
         bad++;
         $display("FAIL clean_busy_cycles: got %0d want 1024", bcnt + bacc);
      end
      total++;
      if (done1 !== 1'b1 || pass1 !== 1'b1 || busy1 !== 1'b0 || err1 !== 10'd0) begin
         bad++;
         $display("FAIL clean_result: got done=%b pass=%b busy=%b err=%0d want 1 1 0 0",
                  done1, pass1, busy1, err1);
      end
      total++;
      if ({a1, b1, c1} !== 9'h1FF) begin
         bad++;
         $display("FAIL clean_last_operands: got %h want 1ff", {a1, b1, c1});
      end
   endtask

   // Runs a sweep on the settle-1 instance and checks it against the scoreboard.
   task automatic run_fault_sweep(input string name);
      int edges, bcnt;
      logic [9:0] exp_err;
      logic [8:0] exp_first;
      logic       exp_pass;
      build_expected();
      exp_err   = 10'(exp_q.size());
      exp_first = (exp_q.size() != 0) ? exp_q[0] : 9'd0;
      exp_pass  = (exp_q.size() == 0);
      apply_reset();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_sweep(0);
      wait_done(1, 1100, edges, bcnt);
      total++;
      if (edges != 1024) begin
         bad++;
         $display("FAIL %s_latency: got %0d want 1024", name, edges);
      end
      total++;
      if (err1 !== exp_err) begin
         bad++;
         $display("FAIL %s_err_count: got %0d want %0d", name, err1, exp_err);
      end
      total++;
      if (pass1 !== exp_pass) begin
         bad++;
         $display("FAIL %s_pass: got %b want %b", name, pass1, exp_pass);
      end
      if (exp_err != 10'd0) begin
         total++;
         if (fail1 !== exp_first) begin
            bad++;
            $display("FAIL %s_fail_vec: got %0d want %0d", name, fail1, exp_first);
         end
      end
   endtask

   task automatic test_sum_fault();
      clear_faults();
      fault_mode = 1;
      run_fault_sweep("sum_fault");
   endtask

   task automatic test_carry_fault();
      clear_faults();
      fault_mode = 2;
      run_fault_sweep("carry_fault");
   endtask

   task automatic test_random_faults();
      for (int it = 0; it < 2; it++) begin
         clear_faults();
         fault_mode = 3;
         fault_mask = 5'($urandom_range(1, 31));
         for (int i = 0; i < 512; i++) fault_map[i] = ($urandom_range(0, 7) == 0);
         run_fault_sweep("random_faults");
      end
      clear_faults();
      fault_mode = 3;
      fault_mask = 5'($urandom_range(1, 31));
      fault_map[$urandom_range(0, 511)] = 1'b1;
      run_fault_sweep("single_fault");
      clear_faults();
   endtask

   task automatic test_mid_sweep();
      int edges, bcnt;
      apply_reset();
      clear_faults();
      start_sweep(0);
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         if (n == 101 || n == 150) begin
            total++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || {a1, b1, c1} !== 9'(n / 2)) begin
               bad++;
               $display("FAIL mid_sweep_progress_%0d: got busy=%b done=%b vec=%0d want 1 0 %0d",
                        n, busy1, done1, {a1, b1, c1}, n / 2);
            end
         end
         if (n == 99)  start = 1'b1;
         if (n == 100) start = 1'b0;
         if (n == 299) rst = 1'b1;
         if (n == 300) begin
            total++;
            if ({a1, b1, c1, busy1, done1, pass1, err1, fail1} !== 32'd0 || st1 !== ST_IDLE) begin
               bad++;
               $display("FAIL mid_sweep_reset: got %h state=%0d want 0 state=%0d",
                        {a1, b1, c1, busy1, done1, pass1, err1, fail1}, st1, ST_IDLE);
            end
            rst = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      start_sweep(0);
      wait_done(1, 1100, edges, bcnt);
      total++;
      if (edges != 1024 || pass1 !== 1'b1) begin
         bad++;
         $display("FAIL mid_sweep_rerun: got edges=%0d pass=%b want 1024 1", edges, pass1);
      end
   endtask

   task automatic test_restart_slow();
      int edges, bcnt;
      apply_reset();
      clear_faults();
      start_sweep(0);
      wait_done(3, 2200, edges, bcnt);
      total++;
      if (edges != 2048 || pass3 !== 1'b1) begin
         bad++;
         $display("FAIL slow_first_sweep: got edges=%0d pass=%b want 2048 1", edges, pass3);
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
      total++;
      if (done3 !== 1'b1 || pass3 !== 1'b1 || st3 !== ST_DONE) begin
         bad++;
         $display("FAIL slow_done_hold: got done=%b pass=%b state=%0d want 1 1 %0d",
                  done3, pass3, st3, ST_DONE);
      end
      start_sweep(0);
      total++;
      if (done3 !== 1'b0 || pass3 !== 1'b0 || busy3 !== 1'b1) begin
         bad++;
         $display("FAIL slow_restart_clear: got done=%b pass=%b busy=%b want 0 0 1",
                  done3, pass3, busy3);
      end
      wait_done(3, 2200, edges, bcnt);
      total++;
      if (edges != 2048 || pass3 !== 1'b1) begin
         bad++;
         $display("FAIL slow_second_sweep: got edges=%0d pass=%b want 2048 1", edges, pass3);
      end
   endtask

   task automatic test_back_to_back();
      int edges, bcnt;
      apply_reset();
      clear_faults();
      start_sweep(1);
      wait_done(1, 1100, edges, bcnt);
      total++;
      if (edges != 1024 || done1 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_done: got edges=%0d done=%b want 1024 1", edges, done1);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if (done1 !== 1'b0 || pass1 !== 1'b0 || busy1 !== 1'b1 || {a1, b1, c1} !== 9'd0) begin
         bad++;
         $display("FAIL b2b_relaunch: got done=%b pass=%b busy=%b vec=%0d want 0 0 1 0",
                  done1, pass1, busy1, {a1, b1, c1});
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;
      clear_faults();

      test_reset();
      test_clean_sweep();
      test_sum_fault();
      test_carry_fault();
      test_random_faults();
      test_mid_sweep();
      test_restart_slow();
      test_back_to_back();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
